if_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the decode stage; it produces the PC/instruction pair that decode latches every cycle.
- Issues in-order requests to a variable-latency instruction memory and tracks them in a DEPTH-entry in-order queue.
- Applies decode's pause and flushes wrong-path work on a branch redirect (from execute) or a jump redirect (from decode).
- Presents a NOP bubble whenever no valid instruction is available. There are no delay slots.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_inst_queue.sv | 59 +++++
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
    } if_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Circular in-order queue of fetch slots: allocated at request, filled at response, popped by decode.
// Head is combinational from storage; the caller keeps alloc off when full and pop off when empty.
module if_inst_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc,
    input  logic [31:0]              alloc_pc,
    input  logic                     fill,
    input  logic [31:0]              fill_inst,
    input  logic                     pop,
    input  logic                     clear,
    output if_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [AW-1:0] fill_ptr;
    if_entry_t     mem [DEPTH];

    assign head = mem[head_ptr];

    // Fill always targets the oldest unfilled slot, which can never be the slot
    // being allocated or popped in the same cycle, so the three writes are disjoint.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) tail_ptr <= tail_ptr + 1'b1;
            if (fill)  fill_ptr <= fill_ptr + 1'b1;
            if (pop)   head_ptr <= head_ptr + 1'b1;
            count <= count + CW'(alloc) - CW'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && tail_ptr == AW'(i)) begin
                    mem[i] <= '{pc: alloc_pc, inst: IF_NOP, filled: 1'b0};
                end else if (fill && fill_ptr == AW'(i)) begin
                    mem[i].inst   <= fill_inst;
                    mem[i].filled <= 1'b1;
                end else if (pop && head_ptr == AW'(i)) begin
                    mem[i].filled <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: in-order requests to variable-latency imem, PC/inst pair to decode (combinational from queue head).
// Decode pause holds the head; branch/jump redirects flush the queue and drop responses still in flight.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_IF_pause,
    input  logic        i_IF_brTaken,
    input  logic [31:0] i_IF_brTarget,
    input  logic        i_IF_jump,
    input  logic [31:0] i_IF_jumpPC,
    input  logic [25:0] i_IF_lowPC,
    output logic        o_IF_imemReq,
    output logic [31:0] o_IF_imemAddr,
    input  logic        i_IF_imemRdy,
    input  logic        i_IF_imemValid,
    input  logic [31:0] i_IF_imemData,
    output logic        o_IF_valid,
    output logic [31:0] o_IF_PC,
    output logic [31:0] o_IF_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_state_e   state;
    if_state_e   state_nxt;
    logic [31:0] req_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] pending;
    logic [CW-1:0] count;
    if_entry_t   head;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] jump_seq;
    logic [27:0] unused_seq;
    logic        issue;
    logic        drop;
    logic        fill;
    logic        pop;

    assign redirect   = i_IF_brTaken | i_IF_jump;
    assign jump_seq   = i_IF_jumpPC + PC_INC;
    assign unused_seq = jump_seq[27:0];
    // Branch comes from the older instruction, so it wins over a same-cycle jump.
    assign target     = i_IF_brTaken ? i_IF_brTarget : {jump_seq[31:28], i_IF_lowPC, 2'b00};

    assign o_IF_imemReq  = (state == ST_FETCH) && !redirect && (count < CW'(DEPTH));
    assign o_IF_imemAddr = req_pc;
    assign issue         = o_IF_imemReq && i_IF_imemRdy;

    assign drop = i_IF_imemValid && (drop_cnt != '0);
    assign fill = i_IF_imemValid && (drop_cnt == '0) && !redirect;

    assign o_IF_valid = (count != '0) && head.filled && !redirect;
    assign o_IF_PC    = o_IF_valid ? head.pc   : '0;
    assign o_IF_inst  = o_IF_valid ? head.inst : NOP;
    assign pop        = o_IF_valid && !i_IF_pause;

    // On redirect every in-flight request becomes stale; a response landing this cycle is one of them.
    assign pending = drop_cnt + outstanding;
    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect) begin
            drop_nxt = pending - CW'(i_IF_imemValid && (pending != '0));
        end else begin
            drop_nxt = drop_cnt - CW'(drop);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: if (redirect && drop_nxt != '0) state_nxt = ST_FLUSH;
            ST_FLUSH: if (drop_nxt == '0) state_nxt = ST_FETCH;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            req_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            if (redirect) begin
                outstanding <= '0;
                req_pc      <= target;
            end else begin
                outstanding <= outstanding + CW'(issue) - CW'(fill);
                if (issue) req_pc <= req_pc + PC_INC;
            end
        end
    end

    if_inst_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .alloc     (issue),
        .alloc_pc  (req_pc),
        .fill      (fill),
        .fill_inst (i_IF_imemData),
        .pop       (pop),
        .clear     (redirect),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order memory model with programmable latency, scoreboard of decoded pairs.
module tb_if_fetch;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_IF_pause;
    logic        i_IF_brTaken;
    logic [31:0] i_IF_brTarget;
    logic        i_IF_jump;
    logic [31:0] i_IF_jumpPC;
    logic [25:0] i_IF_lowPC;
    logic        o_IF_imemReq;
    logic [31:0] o_IF_imemAddr;
    logic        i_IF_imemRdy;
    logic        i_IF_imemValid;
    logic [31:0] i_IF_imemData;
    logic        o_IF_valid;
    logic [31:0] o_IF_PC;
    logic [31:0] o_IF_inst;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2), .NOP(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_IF_pause     (i_IF_pause),
        .i_IF_brTaken   (i_IF_brTaken),
        .i_IF_brTarget  (i_IF_brTarget),
        .i_IF_jump      (i_IF_jump),
        .i_IF_jumpPC    (i_IF_jumpPC),
        .i_IF_lowPC     (i_IF_lowPC),
        .o_IF_imemReq   (o_IF_imemReq),
        .o_IF_imemAddr  (o_IF_imemAddr),
        .i_IF_imemRdy   (i_IF_imemRdy),
        .i_IF_imemValid (i_IF_imemValid),
        .i_IF_imemData  (i_IF_imemData),
        .o_IF_valid     (o_IF_valid),
        .o_IF_PC        (o_IF_PC),
        .o_IF_inst      (o_IF_inst)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    mem_lat = 1;
    int    cyc = 0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_exp(logic [31:0] pc, logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic wait_req(string name);
        for (int k = 0; k < 40; k++) begin
            if (o_IF_imemReq) break;
            step();
        end
        settle();
        chk(name, 32'(o_IF_imemReq), 32'd1);
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Instruction memory: in-order, one response per cycle, latency counted in edges from the handshake.
    initial begin
        logic        hs;
        logic [31:0] ha;
        logic        rs;
        pend_t       p;
        i_IF_imemValid = 1'b0;
        i_IF_imemData  = '0;
        forever begin
            @(negedge clk);
            hs = o_IF_imemReq && i_IF_imemRdy;
            ha = o_IF_imemAddr;
            rs = rst;
            @(posedge clk);
            #1;
            cyc++;
            if (rs) begin
                pend_q.delete();
                i_IF_imemValid = 1'b0;
                i_IF_imemData  = '0;
            end else begin
                if (hs) begin
                    p.addr = ha;
                    p.due  = cyc + mem_lat - 1;
                    pend_q.push_back(p);
                end
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    i_IF_imemValid = 1'b1;
                    i_IF_imemData  = inst_of(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    i_IF_imemValid = 1'b0;
                    i_IF_imemData  = '0;
                end
            end
        end
    end

    // Monitor: every pair decode consumes must be the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_IF_valid && !i_IF_pause) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got pc %08h inst %08h, expected no output", o_IF_PC, o_IF_inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", o_IF_PC, e.pc);
                    chk("sb_inst", o_IF_inst, e.inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_IF_pause = 1'b0; i_IF_brTaken = 1'b0; i_IF_brTarget = '0;
        i_IF_jump = 1'b0; i_IF_jumpPC = '0; i_IF_lowPC = '0; i_IF_imemRdy = 1'b1;
        step();
        step();
        settle();
        chk("rst_valid", 32'(o_IF_valid), 32'd0);
        chk("rst_req", 32'(o_IF_imemReq), 32'd0);
        chk("rst_addr", o_IF_imemAddr, 32'h0);
        chk("rst_pc", o_IF_PC, 32'h0);
        chk("rst_inst", o_IF_inst, 32'h0);
        chk("rst_state", 32'(dut.state), 32'(ST_BOOT));
        rst = 1'b0;

        // 1: straight-line fetch, latency 1
        push_exp(32'h0, 32'hDEAD_0000);
        push_exp(32'h4, 32'hDEAD_0004);
        push_exp(32'h8, 32'hDEAD_0008);
        push_exp(32'hC, 32'hDEAD_000C);
        step(); settle();
        chk("t1_req", 32'(o_IF_imemReq), 32'd1);
        chk("t1_addr0", o_IF_imemAddr, 32'h0);
        chk("t1_bubble0", 32'(o_IF_valid), 32'd0);
        step(); settle();
        chk("t1_addr4", o_IF_imemAddr, 32'h4);
        chk("t1_bubble1", 32'(o_IF_valid), 32'd0);
        step(); settle();
        chk("t1_first_valid", 32'(o_IF_valid), 32'd1);
        chk("t1_full_noreq", 32'(o_IF_imemReq), 32'd0);

        // 2: pause with 0x8 at the head
        for (int k = 0; k < 20; k++) begin
            if (o_IF_valid && o_IF_PC == 32'h8) break;
            step();
        end
        chk("t2_head8", o_IF_PC, 32'h8);
        i_IF_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_hold_pc", o_IF_PC, 32'h8);
            chk("t2_hold_inst", o_IF_inst, 32'hDEAD_0008);
            chk("t2_full_noreq", 32'(o_IF_imemReq), 32'd0);
            step();
        end
        i_IF_pause   = 1'b0;
        i_IF_imemRdy = 1'b0;
        settle();
        chk("t2_release_pc", o_IF_PC, 32'h8);
        step(); settle();
        chk("t2_no_gap_valid", 32'(o_IF_valid), 32'd1);
        chk("t2_no_gap_pc", o_IF_PC, 32'hC);

        // 5: memory not ready for 4 cycles
        for (int i = 0; i < 4; i++) begin
            chk("t5_req_held", 32'(o_IF_imemReq), 32'd1);
            chk("t5_addr_held", o_IF_imemAddr, 32'h10);
            if (i < 3) begin
                step(); settle();
            end
        end
        chk("t5_cnt_before", 32'(dut.u_queue.count), 32'd0);
        i_IF_imemRdy = 1'b1;
        step(); settle();
        chk("t5_cnt_after", 32'(dut.u_queue.count), 32'd1);
        chk("t5_addr_next", o_IF_imemAddr, 32'h14);

        // reset with a request in flight, then longer memory latency
        rst = 1'b1;
        step(); settle();
        rst = 1'b0;
        mem_lat = 3;
        step(); settle();
        chk("t3_addr0", o_IF_imemAddr, 32'h0);
        step(); settle();
        chk("t3_addr4", o_IF_imemAddr, 32'h4);
        step(); settle();
        chk("t3_outstanding", 32'(dut.outstanding), 32'd2);

        // 3: jump with two responses outstanding
        i_IF_jump = 1'b1; i_IF_jumpPC = 32'h1000_0010; i_IF_lowPC = 26'h000_0040;
        settle();
        chk("t3_bubble_valid", 32'(o_IF_valid), 32'd0);
        chk("t3_bubble_inst", o_IF_inst, 32'h0);
        chk("t3_redirect_noreq", 32'(o_IF_imemReq), 32'd0);
        step();
        i_IF_jump = 1'b0;
        settle();
        chk("t3_state_flush", 32'(dut.state), 32'(ST_FLUSH));
        chk("t3_drop2", 32'(dut.drop_cnt), 32'd2);
        chk("t3_flush_noreq", 32'(o_IF_imemReq), 32'd0);
        push_exp(32'h1000_0100, 32'hCEAD_0100);
        wait_req("t3_req_after_flush");
        chk("t3_new_addr", o_IF_imemAddr, 32'h1000_0100);
        chk("t3_drop0", 32'(dut.drop_cnt), 32'd0);
        drain("t3_drain");

        // 4: branch and jump together, branch wins
        i_IF_brTaken = 1'b1; i_IF_brTarget = 32'h0000_0200;
        i_IF_jump = 1'b1; i_IF_jumpPC = 32'h1000_0010; i_IF_lowPC = 26'h000_0040;
        settle();
        chk("t4_bubble", 32'(o_IF_valid), 32'd0);
        step();
        i_IF_brTaken = 1'b0; i_IF_jump = 1'b0;
        settle();
        chk("t4_reqpc", o_IF_imemAddr, 32'h200);
        push_exp(32'h200, 32'hDEAD_0200);
        wait_req("t4_req");
        chk("t4_addr", o_IF_imemAddr, 32'h200);
        drain("t4_drain");

        // 6: reset while flushing one stale response
        i_IF_pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (dut.outstanding == 2'd1 && !i_IF_imemValid) break;
            step();
        end
        chk("t6_one_outstanding", 32'(dut.outstanding), 32'd1);
        i_IF_brTaken = 1'b1; i_IF_brTarget = 32'h0000_0300;
        step();
        i_IF_brTaken = 1'b0; i_IF_pause = 1'b0;
        settle();
        chk("t6_state_flush", 32'(dut.state), 32'(ST_FLUSH));
        chk("t6_drop1", 32'(dut.drop_cnt), 32'd1);
        rst = 1'b1;
        step(); settle();
        chk("t6_state_boot", 32'(dut.state), 32'(ST_BOOT));
        chk("t6_cnt", 32'(dut.u_queue.count), 32'd0);
        chk("t6_valid", 32'(o_IF_valid), 32'd0);
        chk("t6_noreq", 32'(o_IF_imemReq), 32'd0);
        chk("t6_drop_clr", 32'(dut.drop_cnt), 32'd0);
        rst = 1'b0;
        push_exp(32'h0, 32'hDEAD_0000);
        step(); settle();
        chk("t6_req", 32'(o_IF_imemReq), 32'd1);
        chk("t6_addr", o_IF_imemAddr, 32'h0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
